// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU opcodes, branch condition codes, flag layout,
// and the output-stage state encoding used by the branch unit.
package cpu_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_CMP = 4'd5;
  localparam logic [3:0] OP_MOV = 4'd6;
  localparam logic [3:0] OP_LD  = 4'd7;
  localparam logic [3:0] OP_SHL = 4'd8;
  localparam logic [3:0] OP_SHR = 4'd9;
  localparam logic [3:0] OP_INC = 4'd10;
  localparam logic [3:0] OP_DEC = 4'd11;
  localparam logic [3:0] OP_ST  = 4'd12;
  localparam logic [3:0] OP_JMP = 4'd13;
  localparam logic [3:0] OP_NOP = 4'd14;
  localparam logic [3:0] OP_HLT = 4'd15;

  typedef enum logic [2:0] {
    COND_BE  = 3'b000,
    COND_BLT = 3'b001,
    COND_BLE = 3'b010,
    COND_BNE = 3'b011,
    COND_B   = 3'b100
  } br_cond_t;

  typedef struct packed {
    logic s;
    logic z;
    logic c;
    logic v;
  } flags_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_t;

  // Only arithmetic/logic/shift ops commit flags; moves, memory and control ops do not.
  function automatic logic op_sets_flags(input logic [3:0] op);
    logic r;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_CMP,
      OP_SHL, OP_SHR, OP_INC, OP_DEC: r = 1'b1;
      default:                        r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition decode: flags + condition code -> taken.
module branch_cond_eval
  import cpu_pkg::*;
(
  input  logic [3:0] flags,
  input  logic [2:0] cond,
  output logic       taken
);

  flags_t f;
  logic   flag_c_unused;

  assign f             = flags_t'(flags);
  // Carry is part of the flag word but no condition tests it.
  assign flag_c_unused = f.c;

  // Decode the condition against the supplied flags; reserved codes never branch.
  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_BE:  taken = f.z;
      COND_BLT: taken = f.s ^ f.v;
      COND_BLE: taken = f.z | (f.s ^ f.v);
      COND_BNE: taken = ~f.z;
      COND_B:   taken = 1'b1;
      default:  taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_branch_unit.sv
// Conditional branch resolution unit: tracks committed ALU flags, resolves
// branch requests against (forwarded) flags, and presents one resolved branch
// per cycle through a single-entry valid/ready output stage.
module cond_branch_unit
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  input  logic [3:0]  alu_op,
  input  logic        alu_s,
  input  logic        alu_z,
  input  logic        alu_c,
  input  logic        alu_v,
  input  logic        br_req_valid,
  output logic        br_req_ready,
  input  logic [2:0]  br_cond,
  input  logic [15:0] br_pc,
  input  logic [15:0] br_disp,
  output logic        br_out_valid,
  input  logic        br_out_ready,
  output logic        br_taken,
  output logic [15:0] br_target,
  output logic [3:0]  flags_q,
  output logic [15:0] taken_cnt
);

  out_state_t  state, state_nxt;
  flags_t      flags_r;
  flags_t      flags_fwd;
  logic        flags_wr;
  logic        cond_taken;
  logic        accept;
  logic        out_hs;
  logic [15:0] target_nxt;
  logic        taken_r;
  logic [15:0] target_r;
  logic [15:0] cnt_r;

  // An ALU result in the same cycle is older than the branch, so the branch sees it.
  always_comb begin
    flags_wr  = alu_valid & op_sets_flags(alu_op);
    flags_fwd = flags_r;
    if (flags_wr) begin
      flags_fwd = '{s: alu_s, z: alu_z, c: alu_c, v: alu_v};
    end
  end

  branch_cond_eval u_eval (
    .flags (flags_fwd),
    .cond  (br_cond),
    .taken (cond_taken)
  );

  // Next PC: fall-through is pc+1; taken adds the displacement, wrapping silently.
  always_comb begin
    target_nxt = br_pc + 16'd1;
    if (cond_taken) begin
      target_nxt = br_pc + 16'd1 + br_disp;
    end
  end

  assign br_req_ready = rst_n & ((state == EMPTY) | br_out_ready);
  assign accept       = br_req_valid & br_req_ready;
  assign br_out_valid = (state == FULL);
  assign out_hs       = br_out_valid & br_out_ready;

  // Output stage next state: a new accept refills (no bubble), a lone drain empties.
  always_comb begin
    state_nxt = state;
    if (accept) begin
      state_nxt = FULL;
    end else if (state == FULL && br_out_ready) begin
      state_nxt = EMPTY;
    end
  end

  // State, committed flags, held result and saturating taken counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= EMPTY;
      flags_r  <= '0;
      taken_r  <= 1'b0;
      target_r <= '0;
      cnt_r    <= '0;
    end else begin
      state <= state_nxt;
      if (flags_wr) begin
        flags_r <= flags_fwd;
      end
      if (accept) begin
        taken_r  <= cond_taken;
        target_r <= target_nxt;
      end
      if (out_hs && taken_r && cnt_r != '1) begin
        cnt_r <= cnt_r + 16'd1;
      end
    end
  end

  assign br_taken  = taken_r;
  assign br_target = target_r;
  assign flags_q   = flags_r;
  assign taken_cnt = cnt_r;

endmodule

// File: tb/tb_cond_branch_unit.sv
// Self-checking bench for cond_branch_unit: table-driven flag/condition
// vectors plus hand-written stall, back-to-back, reset and saturation
// sequences; resolved branches are checked against a scoreboard queue.
module tb_cond_branch_unit;

  logic        clk;
  logic        rst_n;
  logic        alu_valid;
  logic [3:0]  alu_op;
  logic        alu_s, alu_z, alu_c, alu_v;
  logic        br_req_valid;
  logic        br_req_ready;
  logic [2:0]  br_cond;
  logic [15:0] br_pc;
  logic [15:0] br_disp;
  logic        br_out_valid;
  logic        br_out_ready;
  logic        br_taken;
  logic [15:0] br_target;
  logic [3:0]  flags_q;
  logic [15:0] taken_cnt;

  cond_branch_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .alu_valid    (alu_valid),
    .alu_op       (alu_op),
    .alu_s        (alu_s),
    .alu_z        (alu_z),
    .alu_c        (alu_c),
    .alu_v        (alu_v),
    .br_req_valid (br_req_valid),
    .br_req_ready (br_req_ready),
    .br_cond      (br_cond),
    .br_pc        (br_pc),
    .br_disp      (br_disp),
    .br_out_valid (br_out_valid),
    .br_out_ready (br_out_ready),
    .br_taken     (br_taken),
    .br_target    (br_target),
    .flags_q      (flags_q),
    .taken_cnt    (taken_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        av;
    logic [3:0]  op;
    logic [3:0]  fl;     // {S,Z,C,V}
    logic        bv;
    logic [2:0]  cond;
    logic [15:0] pc;
    logic [15:0] disp;
    logic        exp_tk;
    logic [15:0] exp_tg;
    logic [3:0]  exp_fl;
  } vec_t;

  typedef struct {
    logic        tk;
    logic [15:0] tg;
  } exp_t;

  exp_t  sb[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc      = 0;
  logic [15:0] model_cnt = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One input cycle: drive at posedge+1, check ready at negedge, check flags after the edge.
  task automatic drive(input logic av, input logic [3:0] op, input logic [3:0] fl,
                       input logic bv, input logic [2:0] cond, input logic [15:0] pc,
                       input logic [15:0] disp, input logic oready, input logic exp_ready,
                       input logic exp_tk, input logic [15:0] exp_tg, input logic [3:0] exp_fl);
    exp_t e;
    alu_valid    = av;
    alu_op       = op;
    {alu_s, alu_z, alu_c, alu_v} = fl;
    br_req_valid = bv;
    br_cond      = cond;
    br_pc        = pc;
    br_disp      = disp;
    br_out_ready = oready;
    @(negedge clk);
    chk("br_req_ready", {31'd0, br_req_ready}, {31'd0, exp_ready});
    if (bv && br_req_ready) begin
      e.tk = exp_tk;
      e.tg = exp_tg;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    chk("flags_q", {28'd0, flags_q}, {28'd0, exp_fl});
  endtask

  // Scoreboard consumer: every output handshake must match the oldest expected result.
  always @(negedge clk) begin
    if (rst_n && br_out_valid && br_out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("br_taken", {31'd0, br_taken}, {31'd0, e.tk});
        chk("br_target", {16'd0, br_target}, {16'd0, e.tg});
        chk("taken_cnt", {16'd0, taken_cnt}, {16'd0, model_cnt});
        if (e.tk && model_cnt != 16'hFFFF) model_cnt = model_cnt + 16'd1;
      end
    end
  end

  always @(posedge clk) begin
    cyc++;
    if (cyc > 90000) begin
      $display("FAIL watchdog: cycle budget exhausted, got %0d expected <= 90000", cyc);
      $fatal(1, "timeout");
    end
  end

  vec_t tbl[15];

  initial begin
    // S Z C V
    tbl[0]  = '{1, 4'd5,  4'b0100, 0, 3'd0, 16'h0000, 16'h0000, 0, 16'h0000, 4'b0100};
    tbl[1]  = '{0, 4'd0,  4'b0000, 1, 3'd0, 16'h0010, 16'h0005, 1, 16'h0016, 4'b0100};
    tbl[2]  = '{1, 4'd1,  4'b1000, 1, 3'd1, 16'h0020, 16'hFFFE, 1, 16'h001F, 4'b1000};
    tbl[3]  = '{1, 4'd0,  4'b0000, 0, 3'd0, 16'h0000, 16'h0000, 0, 16'h0000, 4'b0000};
    tbl[4]  = '{1, 4'd6,  4'b0100, 1, 3'd0, 16'h0030, 16'h0007, 0, 16'h0031, 4'b0000};
    tbl[5]  = '{1, 4'd8,  4'b0001, 1, 3'd2, 16'h0100, 16'h0010, 1, 16'h0111, 4'b0001};
    tbl[6]  = '{1, 4'd12, 4'b0100, 1, 3'd3, 16'h0200, 16'h0003, 1, 16'h0204, 4'b0001};
    tbl[7]  = '{1, 4'd11, 4'b0110, 1, 3'd3, 16'h0300, 16'h0003, 0, 16'h0301, 4'b0110};
    tbl[8]  = '{0, 4'd0,  4'b0000, 1, 3'd2, 16'h0400, 16'h0008, 1, 16'h0409, 4'b0110};
    tbl[9]  = '{1, 4'd3,  4'b1001, 1, 3'd1, 16'h0500, 16'h0004, 0, 16'h0501, 4'b1001};
    tbl[10] = '{0, 4'd0,  4'b0000, 1, 3'd5, 16'h0600, 16'h0001, 0, 16'h0601, 4'b1001};
    tbl[11] = '{0, 4'd0,  4'b0000, 1, 3'd7, 16'h0700, 16'h0001, 0, 16'h0701, 4'b1001};
    tbl[12] = '{1, 4'd7,  4'b0100, 1, 3'd4, 16'h0800, 16'h8000, 1, 16'h8801, 4'b1001};
    tbl[13] = '{1, 4'd15, 4'b1111, 1, 3'd0, 16'h0900, 16'h0001, 0, 16'h0901, 4'b1001};
    tbl[14] = '{1, 4'd4,  4'b0100, 0, 3'd0, 16'h0000, 16'h0000, 0, 16'h0000, 4'b0100};

    rst_n = 1'b0;
    alu_valid = 0; alu_op = '0; {alu_s, alu_z, alu_c, alu_v} = '0;
    br_req_valid = 0; br_cond = '0; br_pc = '0; br_disp = '0; br_out_ready = 0;
    @(negedge clk);
    chk("ready_in_reset", {31'd0, br_req_ready}, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_out_valid", {31'd0, br_out_valid}, 32'd0);
    chk("rst_taken", {31'd0, br_taken}, 32'd0);
    chk("rst_target", {16'd0, br_target}, 32'd0);
    chk("rst_flags", {28'd0, flags_q}, 32'd0);
    chk("rst_cnt", {16'd0, taken_cnt}, 32'd0);
    rst_n = 1'b1;

    // Flag forwarding and condition decode vectors.
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].av, tbl[i].op, tbl[i].fl, tbl[i].bv, tbl[i].cond, tbl[i].pc,
            tbl[i].disp, 1'b1, 1'b1, tbl[i].exp_tk, tbl[i].exp_tg, tbl[i].exp_fl);
    end
    chk("drained_empty", {31'd0, br_out_valid}, 32'd0);

    // Stall: fill with ready low, hold for 3 cycles while new flags and requests arrive.
    drive(0, 4'd0, 4'b0000, 1, 3'd4, 16'h0040, 16'h0004, 0, 1, 1, 16'h0045, 4'b0100);
    for (int i = 0; i < 3; i++) begin
      drive(1, 4'd0, 4'b0001 << i, 1, 3'd4, 16'h0060, 16'h0000, 0, 0, 0, 16'h0000,
            4'b0001 << i);
      chk("stall_valid", {31'd0, br_out_valid}, 32'd1);
      chk("stall_taken", {31'd0, br_taken}, 32'd1);
      chk("stall_target", {16'd0, br_target}, 32'h0045);
    end
    // Back-to-back: one result per cycle, counter advancing each handshake.
    for (int i = 0; i < 3; i++) begin
      drive(0, 4'd0, 4'b0000, 1, 3'd4, 16'h0050 + 16'(i), 16'h0002, 1, 1, 1,
            16'h0053 + 16'(i), 4'b0100);
      chk("b2b_valid", {31'd0, br_out_valid}, 32'd1);
    end
    drive(0, 4'd0, 4'b0000, 0, 3'd0, 16'h0000, 16'h0000, 1, 1, 0, 16'h0000, 4'b0100);
    chk("b2b_drained", {31'd0, br_out_valid}, 32'd0);
    chk("b2b_cnt", {16'd0, taken_cnt}, {16'd0, model_cnt});

    // Reset while FULL with concurrent ALU and branch activity.
    drive(1, 4'd2, 4'b1010, 1, 3'd4, 16'h0070, 16'h0000, 0, 1, 1, 16'h0071, 4'b1010);
    chk("pre_rst_full", {31'd0, br_out_valid}, 32'd1);
    rst_n = 1'b0;
    drive(1, 4'd0, 4'b1111, 1, 3'd4, 16'h0080, 16'h0000, 0, 0, 0, 16'h0000, 4'b0000);
    rst_n = 1'b1;
    chk("midrst_valid", {31'd0, br_out_valid}, 32'd0);
    chk("midrst_cnt", {16'd0, taken_cnt}, 32'd0);
    sb.delete();
    model_cnt = '0;

    // Saturation: 65535 taken handshakes, then a wrapping taken branch.
    for (int i = 0; i < 65535; i++) begin
      drive(0, 4'd0, 4'b0000, 1, 3'd4, 16'(i), 16'h0000, 1, 1, 1, 16'(i) + 16'd1, 4'b0000);
    end
    drive(0, 4'd0, 4'b0000, 1, 3'd4, 16'hFFFF, 16'h0001, 1, 1, 1, 16'h0001, 4'b0000);
    chk("preload_cnt", {16'd0, taken_cnt}, 32'hFFFF);
    drive(0, 4'd0, 4'b0000, 0, 3'd0, 16'h0000, 16'h0000, 1, 1, 0, 16'h0000, 4'b0000);
    chk("sat_cnt", {16'd0, taken_cnt}, 32'hFFFF);
    chk("sat_drained", {31'd0, br_out_valid}, 32'd0);
    chk("sb_empty", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cond_branch_unit.md
COND_BRANCH_UNIT -- requirements
Module: cond_branch_unit

Interface
REQ-001 SHALL have clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have rst_n, input, 1; reset is synchronous and active-low.
REQ-003 SHALL have alu_valid, input, 1, ALU result present this cycle; always accepted.
REQ-004 SHALL have alu_op, input, 4, opcode that produced the result.
REQ-005 SHALL have alu_s / alu_z / alu_c / alu_v, input, 1 each, ALU sign/zero/carry/overflow flags.
REQ-006 SHALL have br_req_valid, input, 1, branch request present.
REQ-007 SHALL have br_req_ready, output, 1, branch request accepted when high with br_req_valid.
REQ-008 SHALL have br_cond, input, 3, condition code.
REQ-009 SHALL have br_pc, input, 16, address of branch instruction.
REQ-010 SHALL have br_disp, input, 16, two's-complement displacement.
REQ-011 SHALL have br_out_valid, output, 1, resolved branch held.
REQ-012 SHALL have br_out_ready, input, 1, consumer accepts resolved branch.
REQ-013 SHALL have br_taken, output, 1, resolved direction.
REQ-014 SHALL have br_target, output, 16, resolved next PC.
REQ-015 SHALL have flags_q, output, 4, committed flags {S,Z,C,V}.
REQ-016 SHALL have taken_cnt, output, 16, count of taken branches delivered.

Function
REQ-017 SHALL update flags_q on alu_valid only for alu_op in {0,1,2,3,4,5,8,9,10,11}; ops 6, 7, 12-15 leave flags_q unchanged.
REQ-018 SHALL treat an ALU result as older than a branch request in the same cycle: the branch evaluates the flags being written that cycle (forwarded), not the old flags_q.
REQ-019 SHALL decode br_cond: 000 BE (Z), 001 BLT (S^V), 010 BLE (Z|(S^V)), 011 BNE (!Z), 100 B (always); 101-111 never taken.
REQ-020 SHALL compute br_target = br_pc + 1 + br_disp modulo 2^16 when taken, br_pc + 1 modulo 2^16 when not taken; wrap-around silent.
REQ-021 SHALL use a two-state output FSM: EMPTY (br_out_valid=0) and FULL (br_out_valid=1).
REQ-022 SHALL drive br_req_ready = (state==EMPTY) | br_out_ready, combinationally.
REQ-023 SHALL, on accepted request in cycle N, present br_out_valid, br_taken, br_target in cycle N+1 (latency 1).
REQ-024 SHALL hold br_taken and br_target stable while FULL and br_out_ready=0.
REQ-025 SHALL, when FULL with br_out_ready=1 and a new request accepted the same cycle, stay FULL with the new result next cycle (back-to-back, no bubble).
REQ-026 SHALL go FULL->EMPTY when br_out_ready=1 and no request is accepted.
REQ-027 SHALL increment taken_cnt by 1 on each output handshake (br_out_valid & br_out_ready) with br_taken=1, saturating at 0xFFFF.
REQ-028 SHALL not let flag updates after acceptance change a held result.

Reset
REQ-029 SHALL, when rst_n=0 at a rising edge, set flags_q=0, state=EMPTY, br_out_valid=0, br_taken=0, br_target=0, taken_cnt=0.
REQ-030 SHALL discard a held (FULL) result and ignore same-cycle alu_valid/br_req_valid when reset is asserted mid-operation.
REQ-031 SHALL hold br_req_ready=0 while rst_n=0.

Structure
REQ-032 SHALL place ALU opcode constants, the br_cond enum and a packed flags struct {S,Z,C,V} in shared package cpu_pkg.
REQ-033 SHALL implement condition decode as combinational sub-module branch_cond_eval (flags, cond -> taken).
REQ-034 SHALL stay within 120-400 RTL lines including the sub-module.

Verification
REQ-035 SHALL cover: ALU op 5 with Z=1, then BE pc=0x0010 disp=0x0005 -> next cycle br_taken=1, br_target=0x0016.
REQ-036 SHALL cover: same-cycle ALU op 1 (S=1,V=0) and BLT pc=0x0020 disp=0xFFFE -> taken, target=0x001F.
REQ-037 SHALL cover: ALU op 6 with Z=1 after op 0 with Z=0, then BE -> not taken, target=pc+1, flags_q unchanged.
REQ-038 SHALL cover: br_out_ready=0 for 3 cycles -> outputs stable, br_req_ready=0; then back-to-back B requests with br_out_ready=1 -> one result per cycle, taken_cnt increments each.
REQ-039 SHALL cover: B pc=0xFFFF disp=0x0001 -> target=0x0001; taken_cnt preloaded to 0xFFFF via 65535 taken handshakes stays 0xFFFF.
REQ-040 SHALL cover: rst_n=0 while FULL -> next cycle br_out_valid=0, flags_q=0, taken_cnt=0.
